// File: rtl/demux8_pkg.sv
// Shared constants and lane-state type for the 8-way write dispatcher.
// Optional broadcast support is enabled by defining DEMUX8_BCAST_EN.
package demux8_pkg;

    localparam int unsigned LANES     = 8;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

endpackage

// File: rtl/dispatch_lane.sv
// One destination lane: a single-entry holding register with a valid/ready handshake.
module dispatch_lane
    import demux8_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free_c
);

    lane_state_e state_q;
    lane_state_e state_d;

    // Lane occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LANE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A write always wins over a drain, so fill-while-draining stays FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            LANE_EMPTY: if (wr) state_d = LANE_FULL;
            LANE_FULL:  if (!wr && ready) state_d = LANE_EMPTY;
            default:    state_d = LANE_EMPTY;
        endcase
    end

    // Data is kept after a drain; only a new write replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr) begin
            data <= din;
        end
    end

    assign valid  = (state_q == LANE_FULL);
    assign free_c = !valid || ready;

endmodule

// File: rtl/demux8_dispatch.sv
// Routes one producer stream to one of 8 independently stalling lanes by select.
// Define DEMUX8_BCAST_EN to add iBcast, which writes all 8 lanes in one transfer.
module demux8_dispatch
    import demux8_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [WIDTH-1:0]       iData,
    input  logic [SEL_W-1:0]       iSel,
    output logic [LANES-1:0]       oValid,
    input  logic [LANES-1:0]       iReady,
    output logic [LANES*WIDTH-1:0] oData,
    output logic [CNT_W-1:0]       oCount,
    output logic                   oBusy
`ifdef DEMUX8_BCAST_EN
    ,
    input  logic                   iBcast
`endif
);

    logic [LANES-1:0] lane_free;
    logic [LANES-1:0] lane_wr;
    logic             acc;
    logic [CNT_W-1:0] cnt_q;

    // Ready decode and write fan-out; ready never looks at iValid
    always_comb begin
        lane_wr = '0;
`ifdef DEMUX8_BCAST_EN
        if (iBcast) begin
            oReady = &lane_free;
        end else begin
            oReady = lane_free[iSel];
        end
`else
        oReady = lane_free[iSel];
`endif
        acc = iValid && oReady;
        if (acc) begin
`ifdef DEMUX8_BCAST_EN
            if (iBcast) begin
                lane_wr = '1;
            end else begin
                lane_wr[iSel] = 1'b1;
            end
`else
            lane_wr[iSel] = 1'b1;
`endif
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dispatch_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr     (lane_wr[k]),
            .ready  (iReady[k]),
            .din    (iData),
            .valid  (oValid[k]),
            .data   (oData[k*WIDTH +: WIDTH]),
            .free_c (lane_free[k])
        );
    end

    // Accepted-transfer counter; a broadcast counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign oCount = cnt_q;
    assign oBusy  = |oValid;

endmodule

// File: tb/tb_demux8_dispatch.sv
// Self-checking bench for demux8_dispatch: directed scenarios plus random traffic vs a lane model.
// Broadcast scenarios run when DEMUX8_BCAST_EN is defined.
module tb_demux8_dispatch;
    import demux8_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic             ready_o;
    logic [W-1:0]     data;
    logic [2:0]       sel;
    logic [7:0]       valid_o;
    logic [7:0]       rdy;
    logic [8*W-1:0]   data_o;
    logic [CW-1:0]    count_o;
    logic             busy_o;
    logic             bcast;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per-lane occupancy and data, and the transfer count
    logic [7:0]   m_valid;
    logic [W-1:0] m_data [8];
    int unsigned  m_cnt;

    always #5 clk = ~clk;

    demux8_dispatch #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iValid (valid),
        .oReady (ready_o),
        .iData  (data),
        .iSel   (sel),
        .oValid (valid_o),
        .iReady (rdy),
        .oData  (data_o),
        .oCount (count_o),
        .oBusy  (busy_o)
`ifdef DEMUX8_BCAST_EN
        ,
        .iBcast (bcast)
`endif
    );

    function automatic logic m_ready();
        logic all_free;
        all_free = 1'b1;
        for (int k = 0; k < 8; k++) if (m_valid[k] && !rdy[k]) all_free = 1'b0;
        if (bcast) return all_free;
        return !m_valid[sel] || rdy[sel];
    endfunction

    function automatic logic [8*W-1:0] m_odata();
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = m_data[k];
        return r;
    endfunction

    function automatic logic [W-1:0] lane(input int k);
        return data_o[k*W +: W];
    endfunction

    task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d, input logic [7:0] r);
        valid = v; sel = s; data = d; rdy = r;
        #1;
    endtask

    // Advance one clock edge and apply the transfer rules to the model
    task automatic step();
        logic acc;
        @(posedge clk);
        acc = valid && m_ready();
        for (int k = 0; k < 8; k++) begin
            if (acc && (bcast || sel == 3'(k))) begin
                m_data[k]  = data;
                m_valid[k] = 1'b1;
            end else if (m_valid[k] && rdy[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        if (acc) m_cnt = (m_cnt + 1) % 65536;
        #1;
    endtask

    task automatic model_clear();
        m_valid = '0;
        m_cnt   = 0;
        for (int k = 0; k < 8; k++) m_data[k] = '0;
    endtask

    task automatic do_reset();
        bcast = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);
        rst_n = 1'b0;
        model_clear();
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_o !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h exp 00", valid_o); end
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", data_o); end
        n_checks++; if (count_o !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h exp 0000", count_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
    endtask

    task automatic test_single_write();
        do_reset();
        drive(1'b1, 3'd3, 32'hDEADBEEF, 8'hFF);
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b exp 1", ready_o); end
        step();
        drive(1'b0, 3'd3, '0, 8'hFF);
        n_checks++; if (valid_o !== 8'h08) begin n_fail++; $display("FAIL single_valid: got %h exp 08", valid_o); end
        n_checks++; if (lane(3) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h exp deadbeef", lane(3)); end
        n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d exp 1", count_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy_o); end
        step();
        n_checks++; if (valid_o !== 8'h00) begin n_fail++; $display("FAIL single_drain: got %h exp 00", valid_o); end
        n_checks++; if (lane(3) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold: got %h exp deadbeef", lane(3)); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 3'd5, 32'h11, ~8'h20);
        step();
        drive(1'b1, 3'd5, 32'h22, ~8'h20);
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b exp 0", ready_o); end
        step();
        n_checks++; if (lane(5) !== 32'h11) begin n_fail++; $display("FAIL stall_data: got %h exp 11", lane(5)); end
        n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("FAIL stall_count: got %0d exp 1", count_o); end
        n_checks++; if (valid_o !== 8'h20) begin n_fail++; $display("FAIL stall_valid: got %h exp 20", valid_o); end
        drive(1'b1, 3'd5, 32'h22, 8'hFF);
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b exp 1", ready_o); end
        step();
        n_checks++; if (lane(5) !== 32'h22) begin n_fail++; $display("FAIL stall_refill_data: got %h exp 22", lane(5)); end
        n_checks++; if (valid_o !== 8'h20) begin n_fail++; $display("FAIL stall_refill_valid: got %h exp 20", valid_o); end
        n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("FAIL stall_refill_count: got %0d exp 2", count_o); end
    endtask

    task automatic test_independent();
        do_reset();
        drive(1'b1, 3'd2, 32'hAAAA, ~8'h04);
        step();
        drive(1'b1, 3'd6, 32'hBBBB, ~8'h04);
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL indep_ready: got %b exp 1", ready_o); end
        step();
        n_checks++; if (lane(6) !== 32'hBBBB) begin n_fail++; $display("FAIL indep_lane6: got %h exp bbbb", lane(6)); end
        n_checks++; if (lane(2) !== 32'hAAAA) begin n_fail++; $display("FAIL indep_lane2: got %h exp aaaa", lane(2)); end
        n_checks++; if (valid_o !== 8'h44) begin n_fail++; $display("FAIL indep_valid: got %h exp 44", valid_o); end
        n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("FAIL indep_count: got %0d exp 2", count_o); end
    endtask

    task automatic test_back_to_back();
        int ready_miss = 0;
        logic [W-1:0] exp_last;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 3'(i % 8), 32'h1000 + 32'(i), 8'hFF);
            if (ready_o !== 1'b1) ready_miss++;
            step();
        end
        n_checks++; if (ready_miss != 0) begin n_fail++; $display("FAIL b2b_ready: got %0d stalled cycles exp 0", ready_miss); end
        n_checks++; if (count_o !== 16'd100) begin n_fail++; $display("FAIL b2b_count: got %0d exp 100", count_o); end
        n_checks++; if (valid_o !== 8'h08) begin n_fail++; $display("FAIL b2b_valid: got %h exp 08", valid_o); end
        for (int k = 0; k < 8; k++) begin
            exp_last = 32'h1000 + 32'((k < 4) ? 96 + k : 88 + k);
            n_checks++;
            if (lane(k) !== exp_last) begin n_fail++; $display("FAIL b2b_lane%0d: got %h exp %h", k, lane(k), exp_last); end
        end
        drive(1'b0, 3'd0, '0, 8'hFF);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 3'(i % 8), 32'(i), 8'hFF);
            step();
        end
        n_checks++; if (count_o !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h exp ffff", count_o); end
        drive(1'b1, 3'd0, 32'h5A5A5A5A, 8'hFF);
        step();
        drive(1'b0, 3'd0, '0, 8'hFF);
        n_checks++; if (count_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h exp 0000", count_o); end
        n_checks++; if (data_o !== m_odata()) begin n_fail++; $display("FAIL wrap_data: got %h exp %h", data_o, m_odata()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 3'd1, 32'h55, 8'h00);
        step();
        drive(1'b1, 3'd7, 32'h66, 8'h00);
        step();
        n_checks++; if (valid_o !== 8'h82) begin n_fail++; $display("FAIL midrst_pre_valid: got %h exp 82", valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (valid_o !== 8'h00) begin n_fail++; $display("FAIL midrst_valid: got %h exp 00", valid_o); end
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL midrst_data: got %h exp 0", data_o); end
        n_checks++; if (count_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_count: got %h exp 0000", count_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", busy_o); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd7, 32'h77, 8'hFF);
        step();
        n_checks++; if (valid_o !== 8'h80 || lane(7) !== 32'h77) begin
            n_fail++; $display("FAIL midrst_recover: got valid %h data %h exp 80 77", valid_o, lane(7));
        end
        n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("FAIL midrst_recover_count: got %0d exp 1", count_o); end
    endtask

    task automatic test_random();
        logic hold = 1'b0;
        logic v;
        logic [2:0] s;
        logic [W-1:0] d;
        do_reset();
        v = 1'b0; s = '0; d = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                s = 3'($urandom_range(0, 7));
                d = $urandom;
`ifdef DEMUX8_BCAST_EN
                bcast = ($urandom_range(0, 7) == 0);
`endif
            end
            drive(v, s, d, 8'($urandom));
            n_checks++;
            if (ready_o !== m_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, ready_o, m_ready()); end
            hold = v && !m_ready();
            step();
            n_checks++; if (valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %h exp %h", i, valid_o, m_valid); end
            n_checks++; if (data_o !== m_odata()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h exp %h", i, data_o, m_odata()); end
            n_checks++; if (count_o !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", i, count_o, m_cnt); end
            n_checks++; if (busy_o !== (|m_valid)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b exp %b", i, busy_o, |m_valid); end
        end
        bcast = 1'b0;
    endtask

`ifdef DEMUX8_BCAST_EN
    task automatic test_bcast();
        do_reset();
        drive(1'b1, 3'd4, 32'h44, ~8'h10);
        step();
        bcast = 1'b1;
        drive(1'b1, 3'd0, 32'hCAFE, ~8'h10);
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bcast_stall_ready: got %b exp 0", ready_o); end
        step();
        n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("FAIL bcast_stall_count: got %0d exp 1", count_o); end
        n_checks++; if (valid_o !== 8'h10) begin n_fail++; $display("FAIL bcast_stall_valid: got %h exp 10", valid_o); end
        drive(1'b1, 3'd0, 32'hCAFE, 8'hFF);
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bcast_ready: got %b exp 1", ready_o); end
        step();
        bcast = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);
        n_checks++; if (valid_o !== 8'hFF) begin n_fail++; $display("FAIL bcast_valid: got %h exp ff", valid_o); end
        n_checks++; if (data_o !== {8{32'hCAFE}}) begin n_fail++; $display("FAIL bcast_data: got %h", data_o); end
        n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("FAIL bcast_count: got %0d exp 2", count_o); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bcast = 1'b0;
        test_reset();
        test_single_write();
        test_stall();
        test_independent();
        test_back_to_back();
        test_reset_mid();
`ifdef DEMUX8_BCAST_EN
        test_bcast();
`endif
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
